// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-word-fall-through FIFO holding 2**ADDR_WIDTH words.
// The head word is always visible on r_data (zero read latency). full and empty
// are registered flags that update on the same edge as the pointers.
//
// The design has two parts:
//   sync_fifo_regfile : storage array, one synchronous write port and one
//                       combinational read port.
//   sync_fifo_ctrl    : read/write pointers, accept decisions and the flags.
//
// Ports (top level):
//   clk     in   1           single clock, rising edge
//   reset   in   1           asynchronous reset, active-low
//   wr      in   1           write request, pushes w_data when accepted
//   rd      in   1           read request, pops the head word when accepted
//   w_data  in   DATA_WIDTH  data to write
//   r_data  out  DATA_WIDTH  current head word mem[rd_ptr]
//   full    out  1           FIFO holds 2**ADDR_WIDTH words
//   empty   out  1           FIFO holds 0 words
//
// Handshake: a request is sampled on each rising edge.
//   - rd is accepted when the FIFO is not empty.
//   - wr is accepted when the FIFO is not full, or when it is full but a read
//     is accepted on the same edge (the slot being freed is the one written).
//   - Requests that are not accepted are dropped silently; nothing is flagged.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sync_fifo_regfile
//   Storage array. Contents are not reset; a reset only clears the pointers.
//   Ports:
//     clk_i      in   1           clock
//     we_i       in   1           write enable
//     waddr_i    in   ADDR_WIDTH  write address
//     wdata_i    in   DATA_WIDTH  write data
//     raddr_i    in   ADDR_WIDTH  read address
//     rdata_o    out  DATA_WIDTH  mem[raddr_i], combinational
// -----------------------------------------------------------------------------
module sync_fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read is asynchronous so the head word falls through with no latency.
  assign rdata_o = mem_q[raddr_i];

endmodule

// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Pointer and flag controller.
//   Ports:
//     clk_i      in   1           clock
//     rst_ni     in   1           asynchronous reset, active-low
//     wr_i       in   1           write request
//     rd_i       in   1           read request
//     we_o       out  1           storage write enable (write accepted)
//     wr_ptr_o   out  ADDR_WIDTH  write pointer
//     rd_ptr_o   out  ADDR_WIDTH  read pointer
//     full_o     out  1           registered full flag
//     empty_o    out  1           registered empty flag
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic                  rd_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic [ADDR_WIDTH-1:0] wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] rd_ptr_inc;
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap naturally modulo the depth.
  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  // A read needs data. A write needs room, except that a simultaneous read
  // on a full FIFO frees the very slot the write lands in.
  assign rd_acc = rd_i && !empty_q;
  assign wr_acc = wr_i && (!full_q || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_inc;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_inc;
    end

    unique case ({wr_acc, rd_acc})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wr_ptr_inc == rd_ptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rd_ptr_inc == wr_ptr_q);
      end
      // Push and pop together leave the occupancy, and so the flags, unchanged.
      2'b11:   ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign we_o     = wr_acc;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// -----------------------------------------------------------------------------
// sync_fifo (top)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty
);

  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  sync_fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wr_i     (wr),
    .rd_i     (rd),
    .we_o     (we),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .full_o   (full),
    .empty_o  (empty)
  );

  sync_fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr),
    .wdata_i (w_data),
    .raddr_i (rd_ptr),
    .rdata_o (r_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed bench for sync_fifo (8 bits x 8 words). Stimulus changes on the
//   falling edge; outputs are sampled 1 time unit after an edge. A queue holds
//   the words the FIFO should contain, in order; its size gives the expected
//   full/empty flags and its front gives the expected head word.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          full;
  logic          empty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .w_data (w_data),
    .r_data (r_data),
    .full   (full),
    .empty  (empty)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags and head word against the scoreboard after an edge.
  task automatic check_state(input string tag);
    check({tag, "_full"},  {31'd0, full},  {31'd0, exp_q.size() == DEPTH});
    check({tag, "_empty"}, {31'd0, empty}, {31'd0, exp_q.size() == 0});
    if (exp_q.size() > 0) begin
      check({tag, "_head"}, {24'd0, r_data}, {24'd0, exp_q[0]});
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // One clock cycle with the given request. The head word is checked before
  // the edge when a read is requested (zero read latency).
  task automatic op(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit acc_r;
    bit acc_w;
    @(negedge clk);
    wr     = w;
    rd     = r;
    w_data = d;
    #1;
    if (r && exp_q.size() > 0) begin
      check({tag, "_pre_rd"}, {24'd0, r_data}, {24'd0, exp_q[0]});
    end
    acc_r = r && (exp_q.size() > 0);
    acc_w = w && ((exp_q.size() < DEPTH) || acc_r);
    @(posedge clk);
    #1;
    if (acc_r) void'(exp_q.pop_front());
    if (acc_w) exp_q.push_back(d);
    check_state(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [DW-1:0] seq3 [6] = '{8'd0, 8'd9, 8'd3, 8'd6, 8'd1, 8'd3};

  initial begin
    reset  = 1'b0;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = '0;

    // 1. Reset, then a read on an empty FIFO.
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    op(1'b0, 1'b1, 8'h00, "rd_on_empty");

    // 2. Three writes then one read.
    op(1'b1, 1'b0, 8'd5, "wr5");
    check("head_5", {24'd0, r_data}, 32'd5);
    op(1'b1, 1'b0, 8'd8, "wr8");
    op(1'b1, 1'b0, 8'd2, "wr2");
    op(1'b0, 1'b1, 8'h00, "rd1");
    check("head_8", {24'd0, r_data}, 32'd8);

    // 3. Fill up; a further write is dropped.
    for (int i = 0; i < 6; i++) op(1'b1, 1'b0, seq3[i], "fill");
    check("full_after_fill", {31'd0, full}, 32'd1);
    op(1'b1, 1'b0, 8'd7, "wr_on_full");
    check("full_stays", {31'd0, full}, 32'd1);

    // 4. Drain; a further read is ignored.
    op(1'b0, 1'b1, 8'h00, "drain0");
    check("full_clear", {31'd0, full}, 32'd0);
    for (int i = 1; i < 8; i++) op(1'b0, 1'b1, 8'h00, "drain");
    check("empty_after_drain", {31'd0, empty}, 32'd1);
    op(1'b0, 1'b1, 8'h00, "rd_past_empty");

    // 5. Simultaneous read/write with 4 words held, across pointer wrap.
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, DW'($urandom_range(0, 255)), "pre4");
    for (int i = 0; i < 10; i++) op(1'b1, 1'b1, DW'($urandom_range(0, 255)), "rw4");
    check("count4", exp_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 8'h00, "post4");
    op(1'b1, 1'b1, 8'h3C, "rw_on_empty");
    check("rw_empty_head", {24'd0, r_data}, 32'h3C);
    op(1'b0, 1'b1, 8'h00, "rw_empty_pop");

    // Simultaneous read/write while full: the freed slot takes the new word.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'($urandom_range(0, 255)), "fill_b");
    for (int i = 0; i < 3; i++) op(1'b1, 1'b1, DW'($urandom_range(0, 255)), "rw_full");
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 8'h00, "drain_b");

    // 6. Reset pulse with 3 words held.
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, DW'(8'h10 + i), "pre_rst");
    idle();
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_full",  {31'd0, full},  32'd0);
    #2;
    reset = 1'b1;
    op(1'b1, 1'b0, 8'hAA, "wr_aa");
    check("head_aa", {24'd0, r_data}, 32'hAA);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
